uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
// - UART receive path: oversamples serial_in_i on a 16x-baud enable, deframes start/data/parity/stop, pushes good bytes into a 16-entry receive FIFO.
// - The host reads the FIFO via a data-present/read-strobe handshake.
// - Companion baud_generator (separate module) produces en_16x_baud_i.
// PARAMETERS
// - FIFO_DEPTH   16  receive FIFO entries (power of 2)
// - AFULL_LEVEL  14  almost-full threshold (count >= AFULL_LEVEL)
// - AEMPTY_LEVEL 2   almost-empty threshold (count <= AEMPTY_LEVEL)
// PORTS
// - clk                    in   1  single system clock
// - rst_n                  in   1  asynchronous active-low reset
// - parity_en_i            in   1  1 = 9th (parity) bit present, even parity
// - msb_first_i            in   1  1 = data bit 7 first, 0 = bit 0 first
// - start_polarity_i       in   1  start-bit level; idle/stop level = ~start_polarity_i
// - serial_in_i            in   1  asynchronous serial line
// - en_16x_baud_i          in   1  one-clk pulse, 16 per bit time
// - read_buffer_i          in   1  one-clk pop strobe
// - reset_buffer_i         in   1  synchronous FIFO flush
// - data_out_o             out  8  oldest FIFO byte (first-word-fall-through); 0 when empty
// - buffer_data_present_o  out  1  FIFO count != 0
// - buffer_full_o          out  1  count == 16
// - buffer_hfull_o         out  1  count >= 8
// - buffer_afull_o         out  1  count >= AFULL_LEVEL
// - buffer_aempty_o        out  1  count <= AEMPTY_LEVEL
// BEHAVIOUR
// - Reset: FSM IDLE, count 0, pointers 0, data_out_o 0, data_present 0, full/hfull/afull 0, aempty 1. Synchronizer flops reset to idle level (1).
// - serial_in_i passes through a 2-flop synchronizer; all sampling is on en_16x_baud_i cycles only.
// - FSM IDLE -> START on the first tick where the synced line == start_polarity_i; tick counter cleared.
// - START: at tick 8, recheck the line; if no longer the start level, return to IDLE (glitch reject). Otherwise go to DATA.
// - DATA: sample each bit every 16 ticks, at mid-bit. 8 bits are shifted in LSB-first, or MSB-first when msb_first_i = 1.
// - PARITY (only if parity_en_i): sample one bit. Error if XOR(data, parity bit) != 0.
// - STOP: sample one bit. Framing error if it != ~start_polarity_i.
// - After the stop sample: a byte with no error is written to the FIFO on the next clk. Any error drops the byte silently. FSM returns to IDLE.
// - Frame length: 10 bits without parity, 11 bits with parity.
// - Config inputs must be static while a frame is in progress; they are sampled live.
// - FIFO pop: read_buffer_i with count > 0 advances rd_ptr. data_out_o shows the next entry the following cycle. Pop when empty is ignored.
// - FIFO push when full: byte dropped, state unchanged.
// - Push and pop in the same cycle: both occur, count unchanged. Allowed when full (pop frees the slot).
// - reset_buffer_i: pointers and count cleared next clk. Takes priority over a push or pop in that cycle. Does not abort the deframer.
// - Latency: data_present rises 2 clk after the stop-bit sample tick.
// - Flags are registered from the count; pointers wrap modulo 16.
// - Mid-frame async reset: the frame is abandoned; the next byte is received from the next start edge.
// STRUCTURE
// - Shared package uart_pkg: FSM state enum (IDLE, START, DATA, PARITY, STOP), constants SOF=8'hAA, EOF=8'hD5, default baud divisor 16'd68.
// - Sub-module uart_rx_fifo: 16x8, first-word-fall-through, with the count flags.
// - Deframer FSM is top-level logic in uart_rx.
// - baud_generator (baud_config_i[15:0]; en_16x_baud_o pulses once every baud_config_i clk) lives alongside, not inside.
// - clkgen is simulation-only.
// TESTING
// - Basic: divisor 68, parity off, LSB-first, send 0x55 -> data_out_o = 0x55, data_present = 1; pop -> data_present = 0, data_out_o = 0.
// - Bit order: msb_first_i = 1, line bits 1,0,1,0,1,0,1,0 -> 0xAA. Same bits with LSB-first -> 0x55.
// - Parity: parity on, send 0xD5 with parity bit 1 -> stored. Same byte with parity bit 0 -> nothing stored.
// - Polarity: start_polarity_i = 1 (idle low), send 0x3C -> 0x3C. Stop bit at the wrong level -> nothing stored.
// - Glitch: start-level pulse of 4 ticks -> no byte stored, FSM back in IDLE.
// - FIFO: 17 bytes, no reads -> hfull at 8, afull at 14, full at 16, 17th dropped, reads return bytes 1..16 in order. reset_buffer_i -> empty, aempty = 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and constants: deframer state encoding, framing bytes, baud and FIFO sizing.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam logic [7:0]  SOF              = 8'hAA;
  localparam logic [7:0]  EOF              = 8'hD5;
  localparam logic [15:0] DEFAULT_BAUD_DIV = 16'd68;

  localparam int FIFO_DEPTH   = 16;
  localparam int AFULL_LEVEL  = 14;
  localparam int AEMPTY_LEVEL = 2;

endpackage

// File: rtl/uart_rx_if.sv
// Host read port of the receiver: FWFT byte, level flags, pop strobe and flush.
interface uart_rx_if;

  logic [7:0] data_out;
  logic       buffer_data_present;
  logic       buffer_full;
  logic       buffer_hfull;
  logic       buffer_afull;
  logic       buffer_aempty;
  logic       read_buffer;
  logic       reset_buffer;

  modport master (
    input  data_out, buffer_data_present, buffer_full, buffer_hfull,
           buffer_afull, buffer_aempty,
    output read_buffer, reset_buffer
  );

  modport slave (
    output data_out, buffer_data_present, buffer_full, buffer_hfull,
           buffer_afull, buffer_aempty,
    input  read_buffer, reset_buffer
  );

endinterface

// File: rtl/baud_generator.sv
// Pulses en_16x_baud_o for one clk every baud_config_i clocks (0 behaves as 1).
// No backpressure; a divisor change takes effect at the next wrap.
module baud_generator (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] baud_config_i,
  output logic        en_16x_baud_o
);

  logic [15:0] cnt_q;
  logic        en_q;
  logic        wrap;

  assign wrap          = ({1'b0, cnt_q} + 17'd1) >= {1'b0, baud_config_i};
  assign en_16x_baud_o = en_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      en_q  <= 1'b0;
    end else begin
      en_q  <= wrap;
      cnt_q <= wrap ? 16'd0 : cnt_q + 16'd1;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO, first-word-fall-through; output byte and flags are registered from the count (1 clk behind).
// Push when full is dropped unless a pop shares the cycle; pop when empty is ignored; flush wins.
module uart_rx_fifo #(
  parameter int DEPTH        = 16,
  parameter int AFULL_LEVEL  = 14,
  parameter int AEMPTY_LEVEL = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic [7:0] push_dat_i,
  input  logic       pop_i,
  input  logic       flush_i,
  output logic [7:0] data_o,
  output logic       present_o,
  output logic       full_o,
  output logic       hfull_o,
  output logic       afull_o,
  output logic       aempty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LVL_FULL   = CW'(DEPTH);
  localparam logic [CW-1:0] LVL_HFULL  = CW'(DEPTH / 2);
  localparam logic [CW-1:0] LVL_AFULL  = CW'(AFULL_LEVEL);
  localparam logic [CW-1:0] LVL_AEMPTY = CW'(AEMPTY_LEVEL);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  logic [7:0] data_q;
  logic       present_q, full_q, hfull_q, afull_q, aempty_q;

  assign do_pop  = pop_i && (count_q != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push_i && ((count_q != LVL_FULL) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!flush_i && do_push) mem[wr_ptr_q] <= push_dat_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      data_q    <= 8'h00;
      present_q <= 1'b0;
      full_q    <= 1'b0;
      hfull_q   <= 1'b0;
      afull_q   <= 1'b0;
      aempty_q  <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      data_q    <= (count_q != '0) ? mem[rd_ptr_q] : 8'h00;
      present_q <= count_q != '0;
      full_q    <= count_q == LVL_FULL;
      hfull_q   <= count_q >= LVL_HFULL;
      afull_q   <= count_q >= LVL_AFULL;
      aempty_q  <= count_q <= LVL_AEMPTY;
    end
  end

  assign data_o    = data_q;
  assign present_o = present_q;
  assign full_o    = full_q;
  assign hfull_o   = hfull_q;
  assign afull_o   = afull_q;
  assign aempty_o  = aempty_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled deframer feeding a 16-entry FWFT FIFO; byte visible 2 clk after the stop sample.
// Host pops via read_buffer; bytes arriving at a full FIFO or with parity/framing errors are dropped.
module uart_rx
  import uart_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      parity_en_i,
  input  logic      msb_first_i,
  input  logic      start_polarity_i,
  input  logic      serial_in_i,
  input  logic      en_16x_baud_i,
  uart_rx_if.slave  host
);

  logic [1:0] sync_q;
  logic       rx;
  rx_state_e  state_q;
  logic [3:0] tick_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic       par_err_q;
  logic       push_q;
  logic [7:0] push_dat_q;

  assign rx = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], serial_in_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      push_q     <= 1'b0;
      push_dat_q <= '0;
    end else begin
      push_q <= 1'b0;
      if (en_16x_baud_i) begin
        case (state_q)
          IDLE: begin
            if (rx == start_polarity_i) begin
              state_q <= START;
              tick_q  <= '0;
            end
          end
          START: begin
            tick_q <= tick_q + 4'd1;
            // Mid start bit: a line back at idle was only a glitch.
            if (tick_q == 4'd7) begin
              if (rx == start_polarity_i) begin
                state_q   <= DATA;
                tick_q    <= '0;
                bit_cnt_q <= '0;
                par_err_q <= 1'b0;
              end else begin
                state_q <= IDLE;
              end
            end
          end
          DATA: begin
            tick_q <= tick_q + 4'd1;
            if (tick_q == 4'd15) begin
              shift_q   <= msb_first_i ? {shift_q[6:0], rx} : {rx, shift_q[7:1]};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) state_q <= parity_en_i ? PARITY : STOP;
            end
          end
          PARITY: begin
            tick_q <= tick_q + 4'd1;
            if (tick_q == 4'd15) begin
              par_err_q <= (^shift_q) ^ rx;
              state_q   <= STOP;
            end
          end
          STOP: begin
            tick_q <= tick_q + 4'd1;
            if (tick_q == 4'd15) begin
              if ((rx == ~start_polarity_i) && !par_err_q) begin
                push_q     <= 1'b1;
                push_dat_q <= shift_q;
              end
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  uart_rx_fifo #(
    .DEPTH        (FIFO_DEPTH),
    .AFULL_LEVEL  (AFULL_LEVEL),
    .AEMPTY_LEVEL (AEMPTY_LEVEL)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push_q),
    .push_dat_i (push_dat_q),
    .pop_i      (host.read_buffer),
    .flush_i    (host.reset_buffer),
    .data_o     (host.data_out),
    .present_o  (host.buffer_data_present),
    .full_o     (host.buffer_full),
    .hfull_o    (host.buffer_hfull),
    .afull_o    (host.buffer_afull),
    .aempty_o   (host.buffer_aempty)
  );

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: drives serial frames through the baud generator and checks the host port.
module tb_uart_rx;
  import uart_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        parity_en;
  logic        msb_first;
  logic        start_pol;
  logic        serial_in;
  logic        en_16x;
  logic [15:0] baud_div;

  int tests;
  int fails;
  int bit_clks;

  uart_rx_if host ();

  baud_generator u_baud (
    .clk           (clk),
    .rst_n         (rst_n),
    .baud_config_i (baud_div),
    .en_16x_baud_o (en_16x)
  );

  uart_rx dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .parity_en_i      (parity_en),
    .msb_first_i      (msb_first),
    .start_polarity_i (start_pol),
    .serial_in_i      (serial_in),
    .en_16x_baud_i    (en_16x),
    .host             (host)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {present, full, hfull, afull, aempty}
  function automatic logic [4:0] flags();
    return {host.buffer_data_present, host.buffer_full, host.buffer_hfull,
            host.buffer_afull, host.buffer_aempty};
  endfunction

  function automatic logic [4:0] exp_flags(input int n);
    return {n != 0, n >= 16, n >= 8, n >= 14, n <= 2};
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_div(input logic [15:0] d);
    baud_div = d;
    bit_clks = int'(d) * 16;
    wait_clks(2 * bit_clks);
  endtask

  task automatic drive_bit(input logic v);
    serial_in = v;
    wait_clks(bit_clks);
  endtask

  // line_bits[0] goes on the wire first
  task automatic send_frame(input logic [7:0] line_bits, input logic use_par,
                            input logic par_bit, input logic stop_lvl);
    drive_bit(start_pol);
    for (int i = 0; i < 8; i++) drive_bit(line_bits[i]);
    if (use_par) drive_bit(par_bit);
    drive_bit(stop_lvl);
    serial_in = ~start_pol;
    wait_clks(2 * bit_clks);
  endtask

  task automatic pop();
    @(negedge clk);
    host.read_buffer = 1'b1;
    @(negedge clk);
    host.read_buffer = 1'b0;
    wait_clks(3);
  endtask

  task automatic flush();
    @(negedge clk);
    host.reset_buffer = 1'b1;
    @(negedge clk);
    host.reset_buffer = 1'b0;
    wait_clks(3);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_clks(4);
    tests++;
    if (host.data_out !== 8'h00) begin
      fails++; $display("FAIL reset_data: got %h expected 00", host.data_out);
    end
    tests++;
    if (flags() !== 5'b00001) begin
      fails++; $display("FAIL reset_flags: got %b expected 00001", flags());
    end
    tests++;
    if (dut.state_q !== IDLE) begin
      fails++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, IDLE);
    end
    rst_n = 1'b1;
    wait_clks(4);
  endtask

  task automatic test_basic();
    set_div(16'd68);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    tests++;
    if (host.data_out !== 8'h55) begin
      fails++; $display("FAIL basic_data: got %h expected 55", host.data_out);
    end
    tests++;
    if (host.buffer_data_present !== 1'b1) begin
      fails++; $display("FAIL basic_present: got %b expected 1", host.buffer_data_present);
    end
    pop();
    tests++;
    if (host.buffer_data_present !== 1'b0) begin
      fails++; $display("FAIL basic_pop_present: got %b expected 0", host.buffer_data_present);
    end
    tests++;
    if (host.data_out !== 8'h00) begin
      fails++; $display("FAIL basic_pop_data: got %h expected 00", host.data_out);
    end
    set_div(16'd4);
  endtask

  task automatic test_bit_order();
    msb_first = 1'b1;
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    tests++;
    if (host.data_out !== 8'hAA) begin
      fails++; $display("FAIL msb_first: got %h expected aa", host.data_out);
    end
    pop();
    msb_first = 1'b0;
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    tests++;
    if (host.data_out !== 8'h55) begin
      fails++; $display("FAIL lsb_first: got %h expected 55", host.data_out);
    end
    pop();
  endtask

  task automatic test_parity();
    parity_en = 1'b1;
    send_frame(8'hD5, 1'b1, 1'b1, 1'b1);
    tests++;
    if ({host.buffer_data_present, host.data_out} !== {1'b1, 8'hD5}) begin
      fails++; $display("FAIL parity_good: got %b/%h expected 1/d5",
                        host.buffer_data_present, host.data_out);
    end
    pop();
    send_frame(8'hD5, 1'b1, 1'b0, 1'b1);
    tests++;
    if (host.buffer_data_present !== 1'b0) begin
      fails++; $display("FAIL parity_bad: present %b expected 0", host.buffer_data_present);
    end
    parity_en = 1'b0;
    flush();
  endtask

  task automatic test_polarity();
    start_pol = 1'b1;
    serial_in = 1'b0;
    wait_clks(3 * bit_clks);
    flush();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    tests++;
    if ({host.buffer_data_present, host.data_out} !== {1'b1, 8'h3C}) begin
      fails++; $display("FAIL polarity_good: got %b/%h expected 1/3c",
                        host.buffer_data_present, host.data_out);
    end
    pop();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    wait_clks(2 * bit_clks);
    tests++;
    if (host.buffer_data_present !== 1'b0) begin
      fails++; $display("FAIL polarity_bad_stop: present %b expected 0", host.buffer_data_present);
    end
    start_pol = 1'b0;
    serial_in = 1'b1;
    wait_clks(3 * bit_clks);
    flush();
  endtask

  task automatic test_glitch();
    serial_in = start_pol;
    wait_clks(4 * int'(baud_div));
    serial_in = ~start_pol;
    wait_clks(bit_clks);
    tests++;
    if (dut.state_q !== IDLE) begin
      fails++; $display("FAIL glitch_state: got %0d expected %0d", dut.state_q, IDLE);
    end
    wait_clks(bit_clks);
    tests++;
    if (host.buffer_data_present !== 1'b0) begin
      fails++; $display("FAIL glitch_present: got %b expected 0", host.buffer_data_present);
    end
  endtask

  task automatic test_fifo();
    logic [7:0] b;
    for (int k = 1; k <= 17; k++) begin
      b = 8'h10 + 8'(k);
      send_frame(b, 1'b0, 1'b0, 1'b1);
      tests++;
      if (flags() !== exp_flags(k > 16 ? 16 : k)) begin
        fails++; $display("FAIL fifo_flags_%0d: got %b expected %b",
                          k, flags(), exp_flags(k > 16 ? 16 : k));
      end
    end
    for (int k = 1; k <= 16; k++) begin
      b = 8'h10 + 8'(k);
      tests++;
      if (host.data_out !== b) begin
        fails++; $display("FAIL fifo_read_%0d: got %h expected %h", k, host.data_out, b);
      end
      pop();
    end
    tests++;
    if (flags() !== exp_flags(0)) begin
      fails++; $display("FAIL fifo_drained: got %b expected %b", flags(), exp_flags(0));
    end
    for (int k = 0; k < 3; k++) send_frame(8'hE0 + 8'(k), 1'b0, 1'b0, 1'b1);
    tests++;
    if (flags() !== exp_flags(3)) begin
      fails++; $display("FAIL fifo_refill: got %b expected %b", flags(), exp_flags(3));
    end
    flush();
    tests++;
    if ({flags(), host.data_out} !== {exp_flags(0), 8'h00}) begin
      fails++; $display("FAIL fifo_flush: got %b/%h expected %b/00",
                        flags(), host.data_out, exp_flags(0));
    end
  endtask

  task automatic test_async_reset();
    drive_bit(start_pol);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rst_n     = 1'b0;
    serial_in = ~start_pol;
    wait_clks(5);
    rst_n = 1'b1;
    wait_clks(2 * bit_clks);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    tests++;
    if ({flags(), host.data_out} !== {exp_flags(1), 8'hA5}) begin
      fails++; $display("FAIL async_reset_frame: got %b/%h expected %b/a5",
                        flags(), host.data_out, exp_flags(1));
    end
    pop();
  endtask

  initial begin
    tests             = 0;
    fails             = 0;
    parity_en         = 1'b0;
    msb_first         = 1'b0;
    start_pol         = 1'b0;
    serial_in         = 1'b1;
    baud_div          = 16'd4;
    bit_clks          = 64;
    host.read_buffer  = 1'b0;
    host.reset_buffer = 1'b0;
    rst_n             = 1'b0;

    test_reset();
    test_basic();
    test_bit_order();
    test_parity();
    test_polarity();
    test_glitch();
    test_fifo();
    test_async_reset();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
